tlfsm_mp: RTL

Multi-phase traffic-light controller: the parametrised successor to the two-direction fixed-cycle light FSM. It sequences N_PHASES signal phases through green, yellow and all-red clearance. Green times are programmable per phase. Optional demand-actuated phase skipping with rest-in-green and a night-flash mode are supported. The block sits between the timing/config register bank and the lamp-driver decode; it owns its down-counter internally.

---
 rtl/tlfsm_mp_if.sv | 29 ++
 rtl/tlfsm_mp.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tlfsm_mp_if.sv
// Signal bundle between the timing/config register bank and the traffic-light
// sequencer. The master drives configuration and demand; the slave reports state.
interface tlfsm_mp_if #(
  parameter int unsigned T_WIDTH  = 8,
  parameter int unsigned N_PHASES = 4
);
  localparam int unsigned PH_W = $clog2(N_PHASES);

  logic [N_PHASES*T_WIDTH-1:0] i_green_time;
  logic [N_PHASES-1:0]         i_req;
  logic                        i_skip_en;
  logic                        i_flash;

  logic [2:0]                  o_state;
  logic [PH_W-1:0]             o_phase;
  logic                        o_flash_on;
  logic [T_WIDTH-1:0]          o_remaining;
  logic [N_PHASES-1:0]         o_pending;

  modport master (
    output i_green_time, i_req, i_skip_en, i_flash,
    input  o_state, o_phase, o_flash_on, o_remaining, o_pending
  );

  modport slave (
    input  i_green_time, i_req, i_skip_en, i_flash,
    output o_state, o_phase, o_flash_on, o_remaining, o_pending
  );
endinterface

// File: rtl/tlfsm_mp.sv
// Multi-phase traffic-light sequencer: GREEN -> YELLOW -> ALLRED per phase,
// programmable green times, demand-actuated skipping with rest-in-green, and
// a night-flash mode entered/left only through all-red clearance.
module tlfsm_mp #(
  parameter int unsigned T_WIDTH    = 8,
  parameter int unsigned N_PHASES   = 4,
  parameter int unsigned Y_TIME     = 3,
  parameter int unsigned AR_TIME    = 2,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  tlfsm_mp_if.slave bus
);
  localparam int unsigned PH_W = $clog2(N_PHASES);

  // Counter load values: a duration T lasts max(T,1) cycles.
  localparam logic [T_WIDTH-1:0] Y_LOAD  = T_WIDTH'((Y_TIME     > 1) ? Y_TIME     - 1 : 0);
  localparam logic [T_WIDTH-1:0] AR_LOAD = T_WIDTH'((AR_TIME    > 1) ? AR_TIME    - 1 : 0);
  localparam logic [T_WIDTH-1:0] FH_LOAD = T_WIDTH'((FLASH_HALF > 1) ? FLASH_HALF - 1 : 0);

  typedef enum logic [2:0] {
    ST_START  = 3'b111,
    ST_GREEN  = 3'b011,
    ST_YELLOW = 3'b010,
    ST_ALLRED = 3'b000,
    ST_FLASH  = 3'b100
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [PH_W-1:0]     next_q, next_d, next_sel;
  logic [T_WIDTH-1:0]  cnt_q, cnt_d;
  logic [N_PHASES-1:0] pend_q, clr;
  logic                flash_q, flash_d;
  logic                others_pending;
  logic                found;
  int unsigned         q;
  logic [T_WIDTH-1:0]  gt [N_PHASES];

  function automatic logic [T_WIDTH-1:0] green_load(input logic [T_WIDTH-1:0] t);
    return (t == '0) ? '0 : t - T_WIDTH'(1);
  endfunction

  // Split the packed green-time bus into per-phase values.
  always_comb begin
    for (int unsigned k = 0; k < N_PHASES; k++) begin
      gt[k] = bus.i_green_time[k*T_WIDTH +: T_WIDTH];
    end
  end

  // Next phase: plain round-robin, or first pending phase after the current one.
  always_comb begin
    next_sel = PH_W'((32'(phase_q) + 1) % N_PHASES);
    found    = 1'b0;
    q        = 0;
    if (bus.i_skip_en) begin
      for (int unsigned i = 1; i < N_PHASES; i++) begin
        q = (32'(phase_q) + i) % N_PHASES;
        if (!found && pend_q[q[PH_W-1:0]]) begin
          next_sel = PH_W'(q);
          found    = 1'b1;
        end
      end
    end
  end

  // Demand from any phase other than the one currently green.
  always_comb begin
    others_pending = |(pend_q & ~(N_PHASES'(1) << phase_q));
  end

  // Next-state, counter reload and demand-clear decode.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    next_d  = next_q;
    cnt_d   = cnt_q - T_WIDTH'(1);
    flash_d = flash_q;
    clr     = '0;
    case (state_q)
      ST_START: begin
        if (cnt_q == '0) begin
          if (bus.i_flash) begin
            state_d = ST_FLASH;
            flash_d = 1'b1;
            cnt_d   = FH_LOAD;
          end else begin
            state_d = ST_GREEN;
            phase_d = '0;
            cnt_d   = green_load(gt[0]);
            clr[0]  = 1'b1;
          end
        end
      end
      ST_GREEN: begin
        if (cnt_q == '0) begin
          if (bus.i_skip_en && !others_pending) begin
            cnt_d = green_load(gt[phase_q]);
          end else begin
            state_d = ST_YELLOW;
            cnt_d   = Y_LOAD;
          end
        end
      end
      ST_YELLOW: begin
        if (cnt_q == '0) begin
          state_d = ST_ALLRED;
          cnt_d   = AR_LOAD;
          next_d  = next_sel;
        end
      end
      ST_ALLRED: begin
        if (cnt_q == '0) begin
          if (bus.i_flash) begin
            state_d = ST_FLASH;
            flash_d = 1'b1;
            cnt_d   = FH_LOAD;
          end else begin
            state_d     = ST_GREEN;
            phase_d     = next_q;
            cnt_d       = green_load(gt[next_q]);
            clr[next_q] = 1'b1;
          end
        end
      end
      ST_FLASH: begin
        if (cnt_q == '0) begin
          if (!bus.i_flash) begin
            state_d = ST_ALLRED;
            next_d  = '0;
            cnt_d   = AR_LOAD;
            flash_d = 1'b0;
          end else begin
            flash_d = ~flash_q;
            cnt_d   = FH_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_ALLRED;
        next_d  = '0;
        cnt_d   = AR_LOAD;
        flash_d = 1'b0;
      end
    endcase
  end

  // State, counter and demand latch registers; set beats clear on pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_START;
      phase_q <= '0;
      next_q  <= '0;
      cnt_q   <= Y_LOAD;
      flash_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      next_q  <= next_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      pend_q  <= (pend_q & ~clr) | bus.i_req;
    end
  end

  assign bus.o_state     = state_q;
  assign bus.o_phase     = phase_q;
  assign bus.o_flash_on  = flash_q;
  assign bus.o_remaining = cnt_q;
  assign bus.o_pending   = pend_q;
endmodule
